mem_port_arbiter: RTL

- Shares the four physical memory ports (mem0 port0/1, mem1 port0/1) among three requesters: core (Control/AGU), host loader, hash DMA.
- Sits between the requesters and the two dual-port 64-bit sync RAMs.
- Routes each request to a port by address bits [ADDR_WIDTH+1:ADDR_WIDTH]: 00=mem0_0, 01=mem0_1, 10=mem1_0, 11=mem1_1.
- Arbitrates each port independently every cycle and returns read data to the owning requester one cycle later.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/port_arb.sv | 101 ++++++++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and helpers for the memory port arbiter
//
// Requester indices, port-select encodings and the round-robin pick helper
// used by both mem_port_arbiter and port_arb.

package mem_arb_pkg;

    localparam int NUM_REQ  = 3;
    localparam int NUM_PORT = 4;

    // Requester indices into req_r/gnt_r/rvalid_r
    localparam int CORE = 0;
    localparam int HOST = 1;
    localparam int HASH = 2;

    // Port-select encodings found in addr_r[ADDR_WIDTH+1:ADDR_WIDTH]
    localparam logic [1:0] MEM0_P0 = 2'b00;
    localparam logic [1:0] MEM0_P1 = 2'b01;
    localparam logic [1:0] MEM1_P0 = 2'b10;
    localparam logic [1:0] MEM1_P1 = 2'b11;

    // Pick one of host/hash. cand[0]=host, cand[1]=hash; ptr=0 favours host.
    // Returns a one-hot grant over all three requesters (core bit always 0).
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [1:0] cand, input logic ptr);
        logic [NUM_REQ-1:0] g;
        if (cand == 2'b11) begin
            g = ptr ? 3'b100 : 3'b010;
        end else begin
            g = {cand, 1'b0};
        end
        return g;
    endfunction

endpackage

// File: rtl/port_arb.sv
// rtl/port_arb.sv - single memory port arbiter with read-return path
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   core_lock      blocks host/hash from this port
//   rr_ptr         global round-robin pointer (0 = host first)
//   req, we        per-requester request (already decoded for this port), write enable
//   starved        host/hash starve counters have reached the limit
//   addr, wdata    per-requester word address and write data (flattened)
//   rd_data        memory read data, valid one cycle after the address
//   gnt            one-hot grant for this port
//   rr_used        a grant on this port was decided by round-robin
//   port_addr, port_wr_en, port_wr_data   memory port drive
//   rvalid, rdata  per-requester read return (flattened), zero when not owner

module port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           core_lock,
    input  logic                           rr_ptr,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [HASH:HOST]               starved,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           rr_used,
    output logic [ADDR_WIDTH-1:0]          port_addr,
    output logic                           port_wr_en,
    output logic [DATA_WIDTH-1:0]          port_wr_data,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rdata
);

    logic [1:0] hh_req;
    logic [1:0] hh_starved;
    logic       rd_fire;
    logic [1:0] rd_idx;
    logic       owner_valid;
    logic [1:0] owner;

    // Priority: starved host/hash, then core, then round-robin host/hash.
    // A starved tie is broken by the pointer but does not count as a
    // round-robin grant, so the pointer only advances on the last tier.
    always_comb begin
        gnt        = '0;
        rr_used    = 1'b0;
        hh_req     = req[HASH:HOST] & {2{~core_lock}};
        hh_starved = hh_req & starved;
        if (hh_starved != 2'b00) begin
            gnt = rr_pick(hh_starved, rr_ptr);
        end else if (req[CORE]) begin
            gnt = 3'b001;
        end else if (hh_req != 2'b00) begin
            gnt     = rr_pick(hh_req, rr_ptr);
            rr_used = 1'b1;
        end
    end

    always_comb begin
        port_addr    = '0;
        port_wr_en   = 1'b0;
        port_wr_data = '0;
        rd_idx       = 2'd0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                port_addr    = addr[r*ADDR_WIDTH +: ADDR_WIDTH];
                port_wr_en   = we[r];
                port_wr_data = we[r] ? wdata[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                rd_idx       = 2'(r);
            end
        end
        rd_fire = |(gnt & ~we);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_valid <= 1'b0;
            owner       <= 2'd0;
        end else begin
            owner_valid <= rd_fire;
            owner       <= rd_idx;
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rvalid[r] = owner_valid && (owner == 2'(r));
            rdata[r*DATA_WIDTH +: DATA_WIDTH] = rvalid[r] ? rd_data : '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares four RAM ports among core, host loader and hash DMA
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   core_lock      1 = host and hash blocked from all ports
//   req_r, we_r    per-requester request / write enable (0=core,1=host,2=hash)
//   addr_r         per-requester {port_sel[1:0], word address}
//   wdata_r        per-requester write data
//   gnt_r          per-requester grant, combinational with req_r
//   rvalid_r       per-requester read valid, one cycle after a granted read
//   rdata_r        per-requester read data
//   mem_addr, mem_wr_en, mem_wr_data   per-port drive, port index = {bank,port}
//   mem_rd_data    per-port read data

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               core_lock,
    input  logic [NUM_REQ-1:0]                 req_r,
    input  logic [NUM_REQ-1:0]                 we_r,
    input  logic [NUM_REQ*(ADDR_WIDTH+2)-1:0]  addr_r,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      wdata_r,
    output logic [NUM_REQ-1:0]                 gnt_r,
    output logic [NUM_REQ-1:0]                 rvalid_r,
    output logic [NUM_REQ*DATA_WIDTH-1:0]      rdata_r,
    output logic [NUM_PORT*ADDR_WIDTH-1:0]     mem_addr,
    output logic [NUM_PORT-1:0]                mem_wr_en,
    output logic [NUM_PORT*DATA_WIDTH-1:0]     mem_wr_data,
    input  logic [NUM_PORT*DATA_WIDTH-1:0]     mem_rd_data
);

    localparam int SEL_W = ADDR_WIDTH + 2;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [NUM_REQ-1:0]            req_eff;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_lo;
    logic [1:0]                    port_sel [NUM_REQ];
    logic [NUM_REQ-1:0]            port_req    [NUM_PORT];
    logic [NUM_REQ-1:0]            port_gnt    [NUM_PORT];
    logic [NUM_REQ-1:0]            port_rvalid [NUM_PORT];
    logic [NUM_REQ*DATA_WIDTH-1:0] port_rdata  [NUM_PORT];
    logic [NUM_PORT-1:0]           rr_used;
    logic                          rr_ptr;
    logic [CNT_W-1:0]              starve_cnt_host;
    logic [CNT_W-1:0]              starve_cnt_hash;
    logic [HASH:HOST]              starved;

    // Requests are masked while reset is held so the combinational grant
    // path shows reset values immediately, not only after the next edge.
    assign req_eff = rstn ? req_r : '0;

    assign starved[HOST] = (starve_cnt_host == CNT_MAX);
    assign starved[HASH] = (starve_cnt_hash == CNT_MAX);

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign addr_lo[r*ADDR_WIDTH +: ADDR_WIDTH] = addr_r[r*SEL_W +: ADDR_WIDTH];
        assign port_sel[r] = addr_r[r*SEL_W + ADDR_WIDTH +: 2];
    end

    for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_dec
            assign port_req[p][r] = req_eff[r] && (port_sel[r] == 2'(p));
        end

        port_arb #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_port_arb (
            .clk          (clk),
            .rstn         (rstn),
            .core_lock    (core_lock),
            .rr_ptr       (rr_ptr),
            .req          (port_req[p]),
            .we           (we_r),
            .starved      (starved),
            .addr         (addr_lo),
            .wdata        (wdata_r),
            .rd_data      (mem_rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .gnt          (port_gnt[p]),
            .rr_used      (rr_used[p]),
            .port_addr    (mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .port_wr_en   (mem_wr_en[p]),
            .port_wr_data (mem_wr_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rvalid       (port_rvalid[p]),
            .rdata        (port_rdata[p])
        );
    end

    // Each requester targets one port, so OR-ing across ports never merges
    // two live values for the same requester.
    always_comb begin
        gnt_r    = '0;
        rvalid_r = '0;
        rdata_r  = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            gnt_r    = gnt_r    | port_gnt[p];
            rvalid_r = rvalid_r | port_rvalid[p];
            rdata_r  = rdata_r  | port_rdata[p];
        end
    end

    // One toggle per cycle even if several ports granted by round-robin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= 1'b0;
        end else if (|rr_used) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Starve counters: clear on idle or grant, hold under core_lock,
    // otherwise count denied cycles up to the limit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_host <= '0;
            starve_cnt_hash <= '0;
        end else begin
            if (!req_eff[HOST] || gnt_r[HOST]) begin
                starve_cnt_host <= '0;
            end else if (!core_lock && starve_cnt_host != CNT_MAX) begin
                starve_cnt_host <= starve_cnt_host + CNT_W'(1);
            end

            if (!req_eff[HASH] || gnt_r[HASH]) begin
                starve_cnt_hash <= '0;
            end else if (!core_lock && starve_cnt_hash != CNT_MAX) begin
                starve_cnt_hash <= starve_cnt_hash + CNT_W'(1);
            end
        end
    end

endmodule
